// File: rtl/int_dispatch_ctrl_if.sv
// Signal bundle between the interrupt dispatch controller and the peripherals / core control path.
// All request inputs are single-cycle pulses sampled on the rising clock edge; there is no back-pressure.
interface int_dispatch_ctrl_if #(
    parameter int NUM_IRQ = 5
);
    logic [NUM_IRQ-1:0] irq_pulse;
    logic               if_wr;
    logic [NUM_IRQ-1:0] if_wdata;
    logic               ie_wr;
    logic [NUM_IRQ-1:0] ie_wdata;
    logic               ei;
    logic               di;
    logic               reti;
    logic               instr_boundary;

    logic [NUM_IRQ-1:0] if_q;
    logic [NUM_IRQ-1:0] ie_q;
    logic               ime;
    logic               int_pending;
    logic               dispatch_busy;
    logic               push_hi;
    logic               push_lo;
    logic [2:0]         pc_sel;
    logic [2:0]         int_pc_in;
    logic [2:0]         dbg_state;

    modport master (
        output irq_pulse, if_wr, if_wdata, ie_wr, ie_wdata, ei, di, reti, instr_boundary,
        input  if_q, ie_q, ime, int_pending, dispatch_busy, push_hi, push_lo, pc_sel,
               int_pc_in, dbg_state
    );

    modport slave (
        input  irq_pulse, if_wr, if_wdata, ie_wr, ie_wdata, ei, di, reti, instr_boundary,
        output if_q, ie_q, ime, int_pending, dispatch_busy, push_hi, push_lo, pc_sel,
               int_pc_in, dbg_state
    );
endinterface

// File: rtl/int_dispatch_ctrl.sv
// Interrupt controller (IF/IE/IME) and fixed-length dispatch sequencer driving the stack path and pc_mod.
// Define INT_DISPATCH_CANCEL_EN to re-pick the vector in PUSH_LO and jump to 0x0000 if nothing is left pending.
module int_dispatch_ctrl #(
    parameter int NUM_IRQ       = 5,
    parameter int DISPATCH_WAIT = 2
) (
    input logic clock,
    input logic reset,
    int_dispatch_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_PUSH_HI = 3'd2,
        S_PUSH_LO = 3'd3,
        S_LOAD    = 3'd4
    } state_t;

    function automatic logic [2:0] lowest_set(input logic [NUM_IRQ-1:0] v);
        lowest_set = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

    state_t             state_q, state_d;
    logic [1:0]         wait_q, wait_d;
    logic [2:0]         idx_q, idx_d;
    logic               cancel_q, cancel_d;
    logic [NUM_IRQ-1:0] if_r, if_d;
    logic [NUM_IRQ-1:0] ie_r, ie_d;
    logic               ime_r, ime_d;
    logic               eip_q, eip_d;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] pending;
    logic               take;

    logic       busy_q, busy_d;
    logic       push_hi_q, push_hi_d;
    logic       push_lo_q, push_lo_d;
    logic [2:0] pc_sel_q, pc_sel_d;
    logic [2:0] int_pc_in_q, int_pc_in_d;

    assign pending = if_r & ie_r;
    assign take    = (state_q == S_IDLE) && bus.instr_boundary && ime_r && (|pending);

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        idx_d    = idx_q;
        cancel_d = cancel_q;
        ie_d     = bus.ie_wr ? bus.ie_wdata : ie_r;
        ime_d    = ime_r;
        eip_d    = eip_q;
        clr      = '0;

        case (state_q)
            S_IDLE: begin
                // di dominates; the take decision below still sees the old IME
                if (bus.di) begin
                    ime_d = 1'b0;
                    eip_d = 1'b0;
                end else begin
                    if (bus.instr_boundary && eip_q) begin
                        ime_d = 1'b1;
                        eip_d = 1'b0;
                    end
                    if (bus.reti) ime_d = 1'b1;
                    if (bus.ei)   eip_d = 1'b1;
                end
                if (take) begin
                    idx_d    = lowest_set(pending);
                    cancel_d = 1'b0;
                    ime_d    = 1'b0;
                    if (DISPATCH_WAIT == 0) begin
                        state_d = S_PUSH_HI;
                    end else begin
                        state_d = S_WAIT;
                        wait_d  = 2'(DISPATCH_WAIT - 1);
                    end
                end
            end
            S_WAIT: begin
                if (wait_q == 2'd0) state_d = S_PUSH_HI;
                else                wait_d  = wait_q - 2'd1;
            end
            S_PUSH_HI: state_d = S_PUSH_LO;
            S_PUSH_LO: begin
                state_d = S_LOAD;
`ifdef INT_DISPATCH_CANCEL_EN
                idx_d    = lowest_set(pending);
                cancel_d = ~(|pending);
`else
                idx_d    = idx_q;
                cancel_d = 1'b0;
`endif
            end
            S_LOAD: begin
                state_d = S_IDLE;
                if (!cancel_q) begin
                    for (int i = 0; i < NUM_IRQ; i++) begin
                        if (idx_q == 3'(i)) clr[i] = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A fresh pulse on the bit being acknowledged wins over the clear
        if_d = ((bus.if_wr ? bus.if_wdata : if_r) & ~clr) | bus.irq_pulse;

        busy_d      = (state_d != S_IDLE);
        push_hi_d   = (state_d == S_PUSH_HI);
        push_lo_d   = (state_d == S_PUSH_LO);
        pc_sel_d    = (state_d == S_LOAD) ? (cancel_d ? 3'd4 : 3'd3) : 3'd0;
        int_pc_in_d = (state_d == S_LOAD && !cancel_d) ? idx_d : 3'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_q      <= 2'd0;
            idx_q       <= 3'd0;
            cancel_q    <= 1'b0;
            if_r        <= '0;
            ie_r        <= '0;
            ime_r       <= 1'b0;
            eip_q       <= 1'b0;
            busy_q      <= 1'b0;
            push_hi_q   <= 1'b0;
            push_lo_q   <= 1'b0;
            pc_sel_q    <= 3'd0;
            int_pc_in_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            idx_q       <= idx_d;
            cancel_q    <= cancel_d;
            if_r        <= if_d;
            ie_r        <= ie_d;
            ime_r       <= ime_d;
            eip_q       <= eip_d;
            busy_q      <= busy_d;
            push_hi_q   <= push_hi_d;
            push_lo_q   <= push_lo_d;
            pc_sel_q    <= pc_sel_d;
            int_pc_in_q <= int_pc_in_d;
        end
    end

    assign bus.if_q          = if_r;
    assign bus.ie_q          = ie_r;
    assign bus.ime           = ime_r;
    assign bus.int_pending   = |pending;
    assign bus.dispatch_busy = busy_q;
    assign bus.push_hi       = push_hi_q;
    assign bus.push_lo       = push_lo_q;
    assign bus.pc_sel        = pc_sel_q;
    assign bus.int_pc_in     = int_pc_in_q;
    assign bus.dbg_state     = state_q;

endmodule
